// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers on wclk.
// Optional WR_ARB_HF_THROTTLE_EN: grants made while half_full is high are limited to one word.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic                          full,
  input  logic                          half_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          w_en,
  output logic [data_width-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] FULL_LIMIT = BW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] limit_q, limit_d;
  logic [BW-1:0] grant_limit;
  logic [BW-1:0] beat_inc;
  logic [IW-1:0] pick, scan, next_ptr;
  logic          pick_valid;
  logic          write;

  // Handshake: a word is consumed from requester i exactly on a cycle with
  // gnt[i]=1 (req[i] acts as valid, gnt[i] as ready); the producer must show
  // its next word, or drop req, on the following cycle.

`ifdef WR_ARB_HF_THROTTLE_EN
  assign grant_limit = half_full ? BW'(1) : FULL_LIMIT;
`else
  logic unused_half_full;
  assign unused_half_full = half_full;
  assign grant_limit      = FULL_LIMIT;
`endif

  // First active request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_valid && req[scan]) begin
        pick_valid = 1'b1;
        pick       = scan;
      end
    end
  end

  assign next_ptr = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
  assign beat_inc = beat_q + 1'b1;
  assign write    = (state_q == BURST) && req[owner_q] && !full && !w_rst;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    limit_d  = limit_q;
    w_en     = 1'b0;
    gnt      = '0;
    data_in  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          owner_d = pick;
          beat_d  = '0;
          limit_d = grant_limit;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          // A dropped request ends the burst even when full is also high.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (!full) begin
          beat_d = beat_inc;
          if (beat_inc == limit_q) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
    endcase
    if (write) begin
      w_en          = 1'b1;
      gnt[owner_q]  = 1'b1;
      data_in       = req_data[int'(owner_q)*data_width +: data_width];
    end
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      limit_q  <= FULL_LIMIT;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      limit_q  <= limit_d;
    end
  end

  assign busy  = (state_q == BURST);
  assign owner = busy ? owner_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model, write scoreboard, cycle-level timing checks.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int W  = NR + DW;

  logic              wclk;
  logic              w_rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic              full;
  logic              half_full;
  logic [NR-1:0]     gnt;
  logic              w_en;
  logic [DW-1:0]     data_in;
  logic [1:0]        owner;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .data_width(DW), .MAX_BURST(4)) dut (
    .wclk(wclk), .w_rst(w_rst), .req(req), .req_data(req_data),
    .full(full), .half_full(half_full), .gnt(gnt), .w_en(w_en),
    .data_in(data_in), .owner(owner), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // ---------------- producer model + scoreboard state ----------------
  int            avail [NR];
  int            seq   [NR];
  logic [NR-1:0] drop;
  logic          hf;
  logic [NR-1:0] gnt_s;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_w;
  int            n_cmp;
  int            n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic load(input int i, input int n);
    avail[i] = n;
    seq[i]   = 0;
  endtask

  task automatic push_burst(input int i, input int s0, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({4'(1 << i), 8'(i * 16 + s0 + k)});
  endtask

  // Drives one cycle's inputs just after the rising edge, returns at the falling edge.
  task automatic tick(input logic f, input logic r);
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (gnt_s[i]) begin
        seq[i]++;
        avail[i]--;
      end
    end
    full      = f;
    w_rst     = r;
    half_full = hf;
    for (int i = 0; i < NR; i++) begin
      req[i]              = (avail[i] > 0) && !drop[i];
      req_data[i*DW +: DW] = 8'(i * 16 + seq[i]);
    end
    @(negedge wclk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge wclk) begin
    gnt_s = gnt;
    if (w_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write @%0t: gnt=%b data_in=%h with nothing expected", $time, gnt, data_in);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_gnt_data", 32'({gnt, data_in}), 32'(exp_w));
      end
    end else begin
      check("idle_gnt_data_zero", 32'({gnt, data_in}), 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    w_rst = 1'b1; full = 1'b0; half_full = 1'b0; hf = 1'b0;
    req = '0; req_data = '0; drop = '0; gnt_s = '0;
    for (int i = 0; i < NR; i++) begin avail[i] = 0; seq[i] = 0; end

    // Reset with every requester active, then round-robin 0,1,2,3,0.
    load(0, 8); load(1, 4); load(2, 4); load(3, 4);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b1);
      check("rst_w_en", 32'(w_en), 0);
      check("rst_gnt", 32'(gnt), 0);
      if (c > 0) check("rst_busy", 32'(busy), 0);
    end
    push_burst(0, 0, 4); push_burst(1, 0, 4); push_burst(2, 0, 4);
    push_burst(3, 0, 4); push_burst(0, 4, 4);
    for (int k = 0; k < 26; k++) begin
      tick(1'b0, 1'b0);
      check("rr_w_en", 32'(w_en), 32'((k % 5 != 0) && (k < 25)));
      check("rr_busy", 32'(busy), 32'((k % 5 != 0) && (k < 25)));
      check("rr_owner", 32'(owner), (k % 5 != 0 && k < 25) ? 32'((k / 5) % 4) : 0);
      if (k == 1) check("first_gnt", 32'(gnt), 32'h1);
    end
    check("drain_rr", exp_q.size(), 0);

    // Single requester 2, two back-to-back bursts with one idle cycle.
    load(2, 8);
    push_burst(2, 0, 8);
    for (int k = 0; k < 11; k++) begin
      tick(1'b0, 1'b0);
      check("single_w_en", 32'(w_en), 32'((k % 5 != 0) && (k < 10)));
      check("single_busy", 32'(busy), 32'((k % 5 != 0) && (k < 10)));
    end
    check("drain_single", exp_q.size(), 0);

    // Full stalls requester 1 for three cycles after its second beat.
    load(1, 4);
    push_burst(1, 0, 4);
    for (int k = 0; k < 9; k++) begin
      tick((k >= 3) && (k <= 5), 1'b0);
      check("stall_w_en", 32'(w_en), 32'(k == 1 || k == 2 || k == 6 || k == 7));
      check("stall_busy", 32'(busy), 32'(k >= 1 && k <= 7));
    end
    check("drain_stall", exp_q.size(), 0);

    // Requester 3 leaves after two beats; the pointer must wrap to 0.
    load(3, 2);
    push_burst(3, 0, 2);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0);
      if (k == 3) begin
        check("early_busy_k3", 32'(busy), 1);
        check("early_w_en_k3", 32'(w_en), 0);
      end
      if (k == 4) check("early_busy_k4", 32'(busy), 0);
    end
    load(0, 1); load(3, 1);
    push_burst(0, 0, 1); push_burst(3, 0, 1);
    for (int k = 5; k < 12; k++) begin
      tick(1'b0, 1'b0);
      if (k == 6) check("rr_after_wrap_gnt", 32'(gnt), 32'h1);
      if (k == 9) check("rr_then_3_gnt", 32'(gnt), 32'h8);
    end
    check("drain_early", exp_q.size(), 0);

    // Reset after requester 2's first beat: no write, arbitration from 0.
    load(2, 4);
    push_burst(2, 0, 1); push_burst(2, 1, 3); push_burst(3, 0, 1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("mrst_beat1_w_en", 32'(w_en), 1);
    tick(1'b0, 1'b1);
    check("mrst_w_en", 32'(w_en), 0);
    check("mrst_gnt", 32'(gnt), 0);
    load(3, 1);
    tick(1'b0, 1'b0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_owner", 32'(owner), 0);
    check("mrst_w_en_idle", 32'(w_en), 0);
    for (int k = 4; k < 12; k++) begin
      tick(1'b0, 1'b0);
      if (k == 4) check("mrst_regrant_gnt", 32'(gnt), 32'h4);
      if (k == 9) check("mrst_next_gnt", 32'(gnt), 32'h8);
    end
    check("drain_mrst", exp_q.size(), 0);

    // half_full high with requesters 0 and 1 active.
    hf = 1'b1;
    load(0, 4); load(1, 4);
`ifdef WR_ARB_HF_THROTTLE_EN
    for (int s = 0; s < 4; s++) begin push_burst(0, s, 1); push_burst(1, s, 1); end
`else
    push_burst(0, 0, 4); push_burst(1, 0, 4);
`endif
    for (int k = 0; k < 17; k++) begin
      tick(1'b0, 1'b0);
`ifdef WR_ARB_HF_THROTTLE_EN
      check("hf_w_en", 32'(w_en), 32'((k % 2 == 1) && (k < 16)));
`else
      check("hf_w_en", 32'(w_en), 32'((k % 5 != 0) && (k < 10)));
`endif
    end
    check("drain_hf", exp_q.size(), 0);
    hf = 1'b0;

    // full and req[owner] drop together: burst ends with no write.
    load(1, 4);
    push_burst(1, 0, 4);
    for (int k = 0; k < 9; k++) begin
      drop[1] = (k == 3);
      tick(k == 3, 1'b0);
      if (k == 3) begin
        check("simul_busy_k3", 32'(busy), 1);
        check("simul_w_en_k3", 32'(w_en), 0);
      end
      if (k == 4) begin
        check("simul_busy_k4", 32'(busy), 0);
        check("simul_w_en_k4", 32'(w_en), 0);
      end
      if (k == 5) check("simul_resume_gnt", 32'(gnt), 32'h2);
    end
    check("drain_simul", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
